go_sequencer: RTL and testbench

- Upstream controller for the go/kill/done worker state machine.
- Accepts a job-batch request over a valid/ready handshake, then issues one `go` pulse per job and waits for each `done`.
- Supervises each job with a watchdog. On timeout or cancel it drives `kill`, retries a bounded number of times, and reports a batch status.

---
 rtl/go_seq_pkg.sv | 33 +++
 rtl/seq_watchdog.sv | 37 +++
 rtl/go_sequencer.sv | 159 +++++++++++++++
 tb/tb_go_sequencer.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/go_seq_pkg.sv
// ----------------------------------------------------------------
// go_seq_pkg : shared types and status codes for go_sequencer
// Rev 1.0
// ----------------------------------------------------------------
`default_nettype none

package go_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_WAIT   = 3'd2,
    S_KILL   = 3'd3,
    S_DRAIN  = 3'd4,
    S_REPORT = 3'd5
  } seq_state_t;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_TIMEOUT = 2'b01;
  localparam logic [1:0] ST_CANCEL  = 2'b10;

  typedef enum logic {
    RSN_TIMEOUT = 1'b0,
    RSN_CANCEL  = 1'b1
  } abort_reason_t;

  function automatic logic [1:0] reason_status(input abort_reason_t rsn);
    return (rsn == RSN_CANCEL) ? ST_CANCEL : ST_TIMEOUT;
  endfunction

endpackage

`default_nettype wire

// File: rtl/seq_watchdog.sv
// ----------------------------------------------------------------
// seq_watchdog : saturating cycle counter, flags LIMIT counted cycles
// Rev 1.0
// ----------------------------------------------------------------
`default_nettype none

module seq_watchdog #(
  parameter int LIMIT = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(LIMIT + 1);
  localparam logic [CW-1:0] C_LAST = CW'(LIMIT - 1);
  localparam logic [CW-1:0] C_MAX  = CW'(LIMIT);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (enable && (r_count != C_MAX)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign expired = (r_count >= C_LAST);

endmodule

`default_nettype wire

// File: rtl/go_sequencer.sv
// ----------------------------------------------------------------
// go_sequencer : issues one go per job, supervises with watchdog/kill/retry
// Rev 1.0
// ----------------------------------------------------------------
`default_nettype none

module go_sequencer
  import go_seq_pkg::*;
#(
  parameter int CNT_W       = 8,
  parameter int TIMEOUT     = 32,
  parameter int KILL_CYCLES = 2,
  parameter int MAX_RETRY   = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [CNT_W-1:0] req_jobs,
  input  logic             cancel,
  output logic             go,
  output logic             kill,
  input  logic             done,
  output logic             busy,
  output logic             seq_done,
  output logic [1:0]       seq_status,
  output logic [CNT_W-1:0] jobs_done
);

  localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [RETRY_W-1:0] C_MAX_RETRY = RETRY_W'(MAX_RETRY);

  seq_state_t          r_state;
  abort_reason_t       r_reason;
  logic [CNT_W-1:0]    r_jobs_total;
  logic [CNT_W-1:0]    r_jobs_done;
  logic [RETRY_W-1:0]  r_retry_cnt;
  logic                r_go;
  logic                r_kill;
  logic                r_seq_done;
  logic [1:0]          r_status;

  logic                w_job_wd_clear;
  logic                w_job_wd_en;
  logic                w_job_expired;
  logic                w_kill_expired;
  logic [CNT_W-1:0]    w_jobs_done_inc;
  logic                w_last_job;

  // The job watchdog runs through LAUNCH and WAIT so its count is cycles since go;
  // a done in WAIT always leaves WAIT, so it restarts the count for the next job.
  assign w_job_wd_en    = (r_state == S_LAUNCH) || (r_state == S_WAIT);
  assign w_job_wd_clear = !w_job_wd_en || ((r_state == S_WAIT) && done);

  seq_watchdog #(.LIMIT(TIMEOUT)) u_job_wd (
    .clk     (clk),
    .reset   (reset),
    .clear   (w_job_wd_clear),
    .enable  (w_job_wd_en),
    .expired (w_job_expired)
  );

  seq_watchdog #(.LIMIT(KILL_CYCLES)) u_kill_tmr (
    .clk     (clk),
    .reset   (reset),
    .clear   (r_state != S_KILL),
    .enable  (r_state == S_KILL),
    .expired (w_kill_expired)
  );

  assign w_jobs_done_inc = r_jobs_done + 1'b1;
  assign w_last_job      = (w_jobs_done_inc == r_jobs_total);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_reason     <= RSN_TIMEOUT;
      r_jobs_total <= '0;
      r_jobs_done  <= '0;
      r_retry_cnt  <= '0;
      r_go         <= 1'b0;
      r_kill       <= 1'b0;
      r_seq_done   <= 1'b0;
      r_status     <= ST_OK;
    end else begin
      r_go       <= 1'b0;
      r_kill     <= 1'b0;
      r_seq_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_jobs_total <= req_jobs;
            r_jobs_done  <= '0;
            r_retry_cnt  <= '0;
            r_status     <= ST_OK;
            if (req_jobs == '0) begin
              r_state    <= S_REPORT;
              r_seq_done <= 1'b1;
            end else begin
              r_state <= S_LAUNCH;
              r_go    <= 1'b1;
            end
          end
        end
        S_LAUNCH: r_state <= S_WAIT;
        S_WAIT: begin
          if (done) begin
            r_jobs_done <= w_jobs_done_inc;
            if (w_last_job || cancel) begin
              // Worker is already idle here, so a cancel needs no kill.
              r_status   <= w_last_job ? ST_OK : ST_CANCEL;
              r_state    <= S_REPORT;
              r_seq_done <= 1'b1;
            end else begin
              r_retry_cnt <= '0;
              r_state     <= S_LAUNCH;
              r_go        <= 1'b1;
            end
          end else if (cancel || w_job_expired) begin
            r_reason <= cancel ? RSN_CANCEL : RSN_TIMEOUT;
            r_state  <= S_KILL;
            r_kill   <= 1'b1;
          end
        end
        S_KILL: begin
          if (w_kill_expired) begin
            r_state <= S_DRAIN;
          end else begin
            r_kill <= 1'b1;
          end
        end
        S_DRAIN: begin
          if ((r_reason == RSN_TIMEOUT) && (r_retry_cnt < C_MAX_RETRY)) begin
            r_retry_cnt <= r_retry_cnt + 1'b1;
            r_state     <= S_LAUNCH;
            r_go        <= 1'b1;
          end else begin
            r_status   <= reason_status(r_reason);
            r_state    <= S_REPORT;
            r_seq_done <= 1'b1;
          end
        end
        S_REPORT: r_state <= S_IDLE;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready  = (r_state == S_IDLE);
  assign busy       = (r_state != S_IDLE);
  assign go         = r_go;
  assign kill       = r_kill;
  assign seq_done   = r_seq_done;
  assign seq_status = r_status;
  assign jobs_done  = r_jobs_done;

endmodule

`default_nettype wire

// File: tb/tb_go_sequencer.sv
// ----------------------------------------------------------------
// tb_go_sequencer : directed self-checking bench for go_sequencer
// Rev 1.0
// ----------------------------------------------------------------
`default_nettype none

module tb_go_sequencer;

  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             req_valid = 1'b0;
  logic [CNT_W-1:0] req_jobs = '0;
  logic             cancel = 1'b0;
  logic             model_done = 1'b0;
  logic             tb_done = 1'b0;
  logic             done_in;
  logic             req_ready, go, kill, busy, seq_done;
  logic [1:0]       seq_status;
  logic [CNT_W-1:0] jobs_done;

  assign done_in = model_done | tb_done;

  always #5 clk = ~clk;

  go_sequencer #(
    .CNT_W(CNT_W), .TIMEOUT(32), .KILL_CYCLES(2), .MAX_RETRY(2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_jobs   (req_jobs),
    .cancel     (cancel),
    .go         (go),
    .kill       (kill),
    .done       (done_in),
    .busy       (busy),
    .seq_done   (seq_done),
    .seq_status (seq_status),
    .jobs_done  (jobs_done)
  );

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Activity monitor, sampled mid-cycle
  int   go_cnt, kill_cnt, kill_rises, seq_done_cnt, last_go_cyc;
  int   overlap = 0, gogo = 0;
  int   gaps [8];
  logic prev_go = 1'b0, prev_kill = 1'b0;

  always @(negedge clk) begin
    if (go) begin
      go_cnt++;
      last_go_cyc = cyc;
    end
    if (kill) begin
      kill_cnt++;
      if (!prev_kill) begin
        if (kill_rises < 8) gaps[kill_rises] = cyc - last_go_cyc;
        kill_rises++;
      end
    end
    if (seq_done) seq_done_cnt++;
    if (go && kill) overlap++;
    if (go && prev_go) gogo++;
    prev_go   = go;
    prev_kill = kill;
  end

  // Worker: done 23 cycles after go; abandons the job on kill
  bit worker_en = 1'b0;
  int wcnt = 0;

  always @(negedge clk) begin
    if (model_done) model_done = 1'b0;
    if (kill || reset) wcnt = 0;
    else if (go && worker_en) wcnt = 23;
    else if (wcnt > 0) begin
      wcnt--;
      if (wcnt == 0) model_done = 1'b1;
    end
  end

  logic [1:0]       got_status;
  logic [CNT_W-1:0] got_jobs;
  int               seq_done_cyc;
  int               drive_cyc;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    go_cnt = 0; kill_cnt = 0; kill_rises = 0; seq_done_cnt = 0; last_go_cyc = 0;
    for (int i = 0; i < 8; i++) gaps[i] = -1;
  endtask

  task automatic start_batch(input int n);
    @(negedge clk);
    req_jobs  = CNT_W'(n);
    req_valid = 1'b1;
    drive_cyc = cyc;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_seq(input string tag, input int bound);
    bit found = 1'b0;
    for (int i = 0; i < bound && !found; i++) begin
      if (seq_done) found = 1'b1;
      else @(negedge clk);
    end
    if (!found) check({tag, " seq_done timeout"}, 0, 1);
    got_status   = seq_status;
    got_jobs     = jobs_done;
    seq_done_cyc = cyc;
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_go(input int n, input int bound);
    bit found = 1'b0;
    for (int i = 0; i < bound && !found; i++) begin
      @(negedge clk);
      if (go_cnt >= n) found = 1'b1;
    end
    if (!found) check("go wait timeout", 0, 1);
  endtask

  task automatic done_cancel_case(input int njobs, input string tag,
                                  input int exp_status);
    clear_mon();
    worker_en = 1'b0;
    start_batch(njobs);
    wait_go(1, 20);
    repeat (5) @(negedge clk);
    tb_done = 1'b1;
    @(negedge clk);
    tb_done = 1'b0;
    wait_go(2, 20);
    repeat (5) @(negedge clk);
    tb_done = 1'b1;
    cancel  = 1'b1;
    @(negedge clk);
    tb_done = 1'b0;
    cancel  = 1'b0;
    wait_seq(tag, 50);
    check({tag, " status"}, got_status, exp_status);
    check({tag, " jobs_done"}, got_jobs, 2);
    check({tag, " kill cycles"}, kill_cnt, 0);
    check({tag, " go pulses"}, go_cnt, 2);
  endtask

  initial begin
    bit found;
    clear_mon();
    repeat (3) @(negedge clk);
    check("reset kill", kill, 0);
    check("reset go", go, 0);
    reset = 1'b0;
    @(negedge clk);
    check("reset req_ready", req_ready, 1);
    check("reset busy", busy, 0);
    check("reset seq_done", seq_done, 0);
    check("reset status", seq_status, 0);
    check("reset jobs_done", jobs_done, 0);

    // Normal batch of 3
    clear_mon();
    worker_en = 1'b1;
    start_batch(3);
    wait_seq("batch3", 300);
    check("batch3 go pulses", go_cnt, 3);
    check("batch3 status", got_status, 0);
    check("batch3 jobs_done", got_jobs, 3);
    check("batch3 kill cycles", kill_cnt, 0);
    check("batch3 seq_done pulses", seq_done_cnt, 1);
    check("batch3 idle ready", req_ready, 1);

    // Empty batch
    clear_mon();
    start_batch(0);
    wait_seq("empty", 10);
    check("empty latency in 1..2", int'((seq_done_cyc - drive_cyc) >= 1 &&
                                        (seq_done_cyc - drive_cyc) <= 2), 1);
    check("empty go pulses", go_cnt, 0);
    check("empty status", got_status, 0);
    check("empty jobs_done", got_jobs, 0);

    // Unresponsive worker: initial launch plus two retries, then TIMEOUT
    clear_mon();
    worker_en = 1'b0;
    start_batch(1);
    wait_seq("timeout", 300);
    check("timeout go pulses", go_cnt, 3);
    check("timeout kill cycles", kill_cnt, 6);
    check("timeout kill aborts", kill_rises, 3);
    for (int i = 0; i < 3; i++) check("timeout go-to-kill gap", gaps[i], 32);
    check("timeout status", got_status, 1);
    check("timeout jobs_done", got_jobs, 0);

    // Cancel 10 cycles into job 2 of 4
    clear_mon();
    worker_en = 1'b1;
    start_batch(4);
    wait_go(2, 60);
    repeat (10) @(negedge clk);
    cancel = 1'b1;
    wait_seq("cancel", 50);
    cancel = 1'b0;
    check("cancel kill cycles", kill_cnt, 2);
    check("cancel status", got_status, 2);
    check("cancel jobs_done", got_jobs, 1);
    repeat (30) @(negedge clk);
    check("cancel go pulses", go_cnt, 2);

    // done and cancel in the same cycle
    done_cancel_case(2, "last-job done+cancel", 0);
    done_cancel_case(3, "mid-batch done+cancel", 2);

    // Reset during KILL
    clear_mon();
    worker_en = 1'b0;
    start_batch(1);
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (kill) found = 1'b1;
    end
    check("reset-in-kill reached KILL", found, 1);
    reset = 1'b1;
    #1;
    check("reset-in-kill kill async", kill, 0);
    check("reset-in-kill busy async", busy, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset-in-kill req_ready", req_ready, 1);
    repeat (40) @(negedge clk);
    check("reset-in-kill no seq_done", seq_done_cnt, 0);
    clear_mon();
    worker_en = 1'b1;
    start_batch(2);
    wait_seq("post-reset", 200);
    check("post-reset status", got_status, 0);
    check("post-reset jobs_done", got_jobs, 2);
    check("post-reset go pulses", go_cnt, 2);

    check("go with kill", overlap, 0);
    check("back-to-back go", gogo, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
